// File: rtl/alu_seq_flags.sv
// alu_seq_flags: multi-cycle ALU with a registered result, registered N/Z/C/V
// flags and valid/ready handshakes on both sides. Single-cycle ops complete
// at the accept edge. Shifts step one bit per cycle. The optional multiply
// is a shift-add loop that is compiled in only when ALU_SEQ_MUL_EN is defined.
module alu_seq_flags #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         nReset,
   input  logic         InValid,
   output logic         InReady,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [3:0]   F,
   output logic         OutValid,
   input  logic         OutReady,
   output logic [N-1:0] Y,
   output logic         Negative,
   output logic         Zero,
   output logic         Carry,
   output logic         Overflow
);
   localparam int SH = $clog2(N);
   localparam int CW = SH + 1;   // wide enough to hold N for the multiply loop

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [3:0]     op_q, op_d;
   logic [N-1:0]   work_q, work_d;   // shift operand, or multiplier / low product half
   logic [N-1:0]   y_q, y_d;
   logic           neg_q, neg_d, zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;
`ifdef ALU_SEQ_MUL_EN
   logic [N-1:0]   hi_q, hi_d;       // high product half
   logic [N-1:0]   mcand_q, mcand_d; // multiplicand
   logic [N:0]     mul_sum;
   logic [2*N-1:0] mul_p;
`endif

   // Shared adder: F[2] selects A-B, which SUB, SLT and SLTU all use.
   logic [N-1:0] b_eff;
   logic [N:0]   sum;
   logic         ovf_add, ovf_sub;
   assign b_eff   = F[2] ? ~B : B;
   assign sum     = {1'b0, A} + {1'b0, b_eff} + {{N{1'b0}}, F[2]};
   assign ovf_add = (~A[N-1] & ~B[N-1] & sum[N-1]) | (A[N-1] & B[N-1] & ~sum[N-1]);
   assign ovf_sub = (A[N-1] & ~B[N-1] & ~sum[N-1]) | (~A[N-1] & B[N-1] & sum[N-1]);

   // Single-cycle result for the op presented on the inputs (shift by 0 passes A).
   logic [N-1:0] alu_y;
   logic         alu_c, alu_v;
   always_comb begin
      alu_y = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (F)
         4'b0000: alu_y = A & B;
         4'b0001: alu_y = A | B;
         4'b0010: begin alu_y = sum[N-1:0]; alu_c = sum[N]; alu_v = ovf_add; end
         4'b0100: alu_y = A & ~B;
         4'b0101: alu_y = A | ~B;
         4'b0110: begin alu_y = sum[N-1:0]; alu_c = sum[N]; alu_v = ovf_sub; end
         4'b0111: begin
            alu_y = {{(N-1){1'b0}}, sum[N-1] ^ ovf_sub};
            alu_c = sum[N];
            alu_v = ovf_sub;
         end
         4'b1000: alu_y = A ^ B;
         4'b1001, 4'b1010, 4'b1011: alu_y = A;
         4'b1100: begin
            alu_y = {{(N-1){1'b0}}, ~sum[N]};
            alu_c = sum[N];
            alu_v = ovf_sub;
         end
         default: alu_y = '0;
      endcase
   end

   // One-bit shift step of the working register; step_out is the bit leaving it.
   logic [N-1:0] step_y;
   logic         step_out;
   always_comb begin
      step_y   = work_q;
      step_out = 1'b0;
      case (op_q)
         4'b1001: begin step_y = {work_q[N-2:0], 1'b0};        step_out = work_q[N-1]; end
         4'b1010: begin step_y = {1'b0, work_q[N-1:1]};        step_out = work_q[0];   end
         4'b1011: begin step_y = {work_q[N-1], work_q[N-1:1]}; step_out = work_q[0];   end
         default: begin step_y = work_q;                        step_out = 1'b0;        end
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   // One shift-add multiply step on the {hi, work} product register.
   assign mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : {(N+1){1'b0}});
   assign mul_p   = {mul_sum, work_q[N-1:1]};
`endif

   // Next-state, handshake outputs and datapath updates.
   logic accept, is_shift, is_mul, commit;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      work_d  = work_q;
      y_d     = y_q;
      neg_d   = neg_q;
      zero_d  = zero_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      commit  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_d    = hi_q;
      mcand_d = mcand_q;
      is_mul  = (F == 4'b1101);
`else
      is_mul  = 1'b0;
`endif
      is_shift = (F == 4'b1001) || (F == 4'b1010) || (F == 4'b1011);
      InReady  = (state_q == IDLE) || ((state_q == DONE) && OutReady);
      OutValid = (state_q == DONE);
      accept   = InValid && InReady;

      case (state_q)
         IDLE: state_d = IDLE;
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
`ifdef ALU_SEQ_MUL_EN
            if (op_q == 4'b1101) begin
               {hi_d, work_d} = mul_p;
               if (cnt_q == CW'(1)) begin
                  y_d     = mul_p[N-1:0];
                  carry_d = |mul_p[2*N-1:N];
                  ovf_d   = 1'b0;
                  commit  = 1'b1;
                  state_d = DONE;
               end
            end else
`endif
            begin
               work_d = step_y;
               if (cnt_q == CW'(1)) begin
                  y_d     = step_y;
                  carry_d = step_out;
                  ovf_d   = 1'b0;
                  commit  = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE: if (OutReady) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // An accept in IDLE or in a draining DONE starts the new op immediately.
      if (accept) begin
         op_d = F;
         if (is_shift && (B[SH-1:0] != '0)) begin
            work_d  = A;
            cnt_d   = {1'b0, B[SH-1:0]};
            state_d = BUSY;
         end else if (is_mul) begin
`ifdef ALU_SEQ_MUL_EN
            work_d  = B;
            hi_d    = '0;
            mcand_d = A;
`endif
            cnt_d   = CW'(N);
            state_d = BUSY;
         end else begin
            y_d     = alu_y;
            carry_d = alu_c;
            ovf_d   = alu_v;
            commit  = 1'b1;
            state_d = DONE;
         end
      end

      if (commit) begin
         neg_d  = y_d[N-1];
         zero_d = (y_d == '0);
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         work_q  <= '0;
         y_q     <= '0;
         neg_q   <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         hi_q    <= '0;
         mcand_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         work_q  <= work_d;
         y_q     <= y_d;
         neg_q   <= neg_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
`ifdef ALU_SEQ_MUL_EN
         hi_q    <= hi_d;
         mcand_q <= mcand_d;
`endif
      end
   end

   assign Y        = y_q;
   assign Negative = neg_q;
   assign Zero     = zero_q;
   assign Carry    = carry_q;
   assign Overflow = ovf_q;

endmodule

// File: tb/tb_alu_seq_flags.sv
// Testbench for alu_seq_flags (N=32). Expected results come from hard-coded
// constants or a behavioural model, are queued when an op is driven and are
// popped when the DUT presents OutValid. ALU_SEQ_MUL_EN selects MUL expectations.
module tb_alu_seq_flags;
   localparam int N = 32;

   logic          clk = 1'b0;
   logic          nReset, InValid, InReady, OutValid, OutReady;
   logic [N-1:0]  A, B, Y;
   logic [3:0]    F;
   logic          Negative, Zero, Carry, Overflow;

   alu_seq_flags #(.N(N)) dut (
      .clk(clk), .nReset(nReset), .InValid(InValid), .InReady(InReady),
      .A(A), .B(B), .F(F), .OutValid(OutValid), .OutReady(OutReady),
      .Y(Y), .Negative(Negative), .Zero(Zero), .Carry(Carry), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] y;
      logic        n, z, c, v;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   int   tests  = 0;
   int   failed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] y, input logic n, z, c, v, input int lat);
      exp_t e;
      e.y = y; e.n = n; e.z = z; e.c = c; e.v = v; e.lat = lat;
      return e;
   endfunction

   // Behavioural reference model.
   function automatic exp_t model(input logic [31:0] a, b, input logic [3:0] f);
      exp_t e;
      logic [32:0] s;
      logic [63:0] p;
      int sh;
      sh = int'(b[4:0]);
      e.y = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 0;
      s = {1'b0, a} + {1'b0, ~b} + 33'd1;
      case (f)
         4'h0: e.y = a & b;
         4'h1: e.y = a | b;
         4'h2: begin
            s = {1'b0, a} + {1'b0, b};
            e.y = s[31:0]; e.c = s[32];
            e.v = (a[31] == b[31]) && (e.y[31] != a[31]);
         end
         4'h4: e.y = a & ~b;
         4'h5: e.y = a | ~b;
         4'h6: begin
            e.y = s[31:0]; e.c = s[32];
            e.v = (a[31] != b[31]) && (e.y[31] != a[31]);
         end
         4'h7: begin
            e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            e.c = s[32]; e.v = (a[31] != b[31]) && (s[31] != a[31]);
         end
         4'h8: e.y = a ^ b;
         4'h9: begin e.y = a << sh; e.c = (sh != 0) ? a[32-sh] : 1'b0; e.lat = sh; end
         4'hA: begin e.y = a >> sh; e.c = (sh != 0) ? a[sh-1] : 1'b0; e.lat = sh; end
         4'hB: begin e.y = $signed(a) >>> sh; e.c = (sh != 0) ? a[sh-1] : 1'b0; e.lat = sh; end
         4'hC: begin
            e.y = (a < b) ? 32'd1 : 32'd0;
            e.c = s[32]; e.v = (a[31] != b[31]) && (s[31] != a[31]);
         end
`ifdef ALU_SEQ_MUL_EN
         4'hD: begin p = {32'd0, a} * {32'd0, b}; e.y = p[31:0]; e.c = |p[63:32]; e.lat = 32; end
`endif
         default: e.y = '0;
      endcase
      e.n = e.y[31];
      e.z = (e.y == 32'd0);
      return e;
   endfunction

   // Pop the oldest expectation and compare it with the presented result.
   task automatic pop_compare(input logic [3:0] f, input logic [31:0] a, b);
      exp_t e;
      check("sb_nonempty", (sb_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         check("out_valid", OutValid, 1);
         check("Y", Y, e.y);
         check("Negative", Negative, e.n);
         check("Zero", Zero, e.z);
         check("Carry", Carry, e.c);
         check("Overflow", Overflow, e.v);
         $display("[TB] F=%h A=%h B=%h -> Y=%h NZCV=%b%b%b%b", f, a, b, Y, Negative, Zero, Carry, Overflow);
      end
   endtask

   // Issue one op (OutReady held high), wait a bounded time for the result.
   task automatic run_op(input logic [31:0] a, b, input logic [3:0] f, input exp_t e);
      int cyc;
      sb_q.push_back(e);
      InValid = 1'b1; A = a; B = b; F = f;
      check("in_ready_at_issue", InReady, 1);
      @(posedge clk); #1;
      InValid = 1'b0;
      cyc = 0;
      while (!OutValid && cyc < 200) begin
         check("in_ready_busy", InReady, 0);
         @(posedge clk); #1;
         cyc++;
      end
      check("latency", cyc, e.lat);
      pop_compare(f, a, b);
   endtask

   initial begin
      logic [3:0] ftab [6];
      exp_t e;
      logic [3:0] rf;
      logic [31:0] ra, rb;
      ftab = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h8, 4'hC};

      // Reset state
      nReset = 1'b0; InValid = 1'b0; OutReady = 1'b1; A = '0; B = '0; F = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", OutValid, 0);
      check("rst_Y", Y, 0);
      check("rst_flags", {28'd0, Negative, Zero, Carry, Overflow}, 0);
      nReset = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", InReady, 1);

      // Directed test-plan cases
      run_op(32'h7FFFFFFF, 32'h1, 4'h2, mk(32'h80000000, 1, 0, 0, 1, 0));
      run_op(32'h5, 32'h5, 4'h6, mk(32'h0, 0, 1, 1, 0, 0));
      run_op(32'h0, 32'h1, 4'h6, mk(32'hFFFFFFFF, 1, 0, 0, 0, 0));
      run_op(32'h80000000, 32'h1, 4'h7, mk(32'h1, 0, 0, 1, 1, 0));
      run_op(32'h80000000, 32'h1, 4'hC, mk(32'h0, 0, 1, 1, 1, 0));
      run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 4'h7, mk(32'h0, 0, 1, 0, 1, 0));
      run_op(32'h80000010, 32'h4, 4'hB, mk(32'hF8000001, 1, 0, 0, 0, 4));
      run_op(32'h80000001, 32'd31, 4'h9, mk(32'h80000000, 1, 0, 0, 0, 31));
      run_op(32'h12345678, 32'd32, 4'hA, mk(32'h12345678, 0, 0, 0, 0, 0));
      run_op(32'hDEADBEEF, 32'h1, 4'h3, mk(32'h0, 0, 1, 0, 0, 0));
`ifdef ALU_SEQ_MUL_EN
      run_op(32'h0000FFFF, 32'h00010001, 4'hD, mk(32'hFFFFFFFF, 1, 0, 0, 0, 32));
`else
      run_op(32'h0000FFFF, 32'h00010001, 4'hD, mk(32'h0, 0, 1, 0, 0, 0));
`endif

      // Back-to-back single-cycle ops, one result per cycle
      for (int i = 0; i < 6; i++) begin
         ra = $urandom; rb = $urandom; rf = ftab[i];
         InValid = 1'b1; A = ra; B = rb; F = rf;
         sb_q.push_back(model(ra, rb, rf));
         @(posedge clk); #1;
         pop_compare(rf, ra, rb);
      end
      InValid = 1'b0;
      @(posedge clk); #1;
      check("drain_out_valid", OutValid, 0);

      // Backpressure: result held stable while OutReady is low
      OutReady = 1'b0;
      InValid = 1'b1; A = 32'hFFFFFFFF; B = 32'h1; F = 4'h2;
      e = mk(32'h0, 0, 1, 1, 0, 0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      InValid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("hold_valid", OutValid, 1);
         check("hold_in_ready", InReady, 0);
         check("hold_Y", Y, e.y);
         check("hold_flags", {28'd0, Negative, Zero, Carry, Overflow},
               {28'd0, e.n, e.z, e.c, e.v});
      end
      OutReady = 1'b1;
      #1;
      check("hold_in_ready_release", InReady, 1);
      pop_compare(4'h2, 32'hFFFFFFFF, 32'h1);
      @(posedge clk); #1;
      check("after_hold_valid", OutValid, 0);

      // Reset during a long shift discards it
      run_op(32'h0000000F, 32'h0, 4'h1, mk(32'hF, 0, 0, 0, 0, 0));
      InValid = 1'b1; A = 32'h1; B = 32'd20; F = 4'h9;
      @(posedge clk); #1;
      InValid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("busy_before_reset", InReady, 0);
      nReset = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_out_valid", OutValid, 0);
      check("mid_rst_in_ready", InReady, 1);
      check("mid_rst_Y", Y, 0);
      nReset = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      check("no_ghost_output", OutValid, 0);

      // Random ops against the model
      for (int i = 0; i < 20; i++) begin
         ra = $urandom; rb = $urandom; rf = 4'($urandom_range(0, 15));
         run_op(ra, rb, rf, model(ra, rb, rf));
      end

      @(posedge clk); #1;
      check("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/alu_seq_flags.md
# alu_seq_flags

- Multi-cycle, parametrised ALU with a registered result and a registered N/Z/C/V flag set.
- Successor to the combinational 32-bit flag ALU. Adds:
  - a 4-bit op code (XOR, unsigned compare, shifts, optional multiply);
  - a correct signed SLT;
  - carry-out;
  - valid/ready handshakes on both the input and output sides.
- Sits between the operand/decode stage and writeback. Throughput is one op per cycle for single-cycle ops; shifts and the optional multiply are iterative.

## Interface

Parameters:
- N, 32, datapath width; power of two, N >= 4. SH = $clog2(N).

Ports:
- clk  in  1  rising-edge clock
- nReset  in  1  synchronous active-low reset
- InValid  in  1  operands/op presented
- InReady  out  1  block accepts this cycle
- A  in  N  operand A
- B  in  N  operand B; shift amount = B[SH-1:0], upper bits ignored for shifts
- F  in  4  op select
- OutValid  out  1  Y/flags valid
- OutReady  in  1  consumer takes result
- Y  out  N  result
- Negative, Zero, Carry, Overflow  out  1 each  flags for Y

## Operation

- Op codes for F = 0xxx keep the legacy encoding: F[2] inverts B and sets carry-in.
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 reserved
  - 0100 A&~B
  - 0101 A|~B
  - 0110 SUB
  - 0111 SLT (signed)
- Op codes for F = 1xxx:
  - 1000 XOR
  - 1001 SLL
  - 1010 SRL
  - 1011 SRA
  - 1100 SLTU
  - 1101 MUL (see Configuration)
  - 1110, 1111 reserved
- Reserved ops: Y=0, Zero=1, Carry=0, Overflow=0. Single-cycle.
- Arithmetic:
  - Sum = A + (F[2] ? ~B : B) + F[2], computed N+1 bits wide. Carry = Sum[N].
  - ADD: Overflow = ~A[N-1]&~B[N-1]&Sum[N-1] | A[N-1]&B[N-1]&~Sum[N-1].
  - SUB: Overflow = A[N-1]&~B[N-1]&~Sum[N-1] | ~A[N-1]&B[N-1]&Sum[N-1].
- SLT: Y = {0, Sum[N-1]^Overflow} using the A-B subtraction. SLTU: Y = {0, ~Carry} of A-B.
- Flags:
  - Negative = Y[N-1]; Zero = (Y == 0), for every op.
  - Carry and Overflow: ADD/SUB as above. Compares report Carry and Overflow of A-B.
  - Logic ops: Carry=0, Overflow=0.
  - Shifts: Carry = last bit shifted out (0 if amount 0); Overflow=0.
- FSM states:
  - IDLE: InReady=1, OutValid=0.
  - BUSY: iterating; InReady=0, OutValid=0.
  - DONE: OutValid=1; InReady = OutReady.
- Accept = InValid & InReady at a rising edge. On accept:
  - Single-cycle ops (including shift by 0) → DONE with the result registered.
  - Shift by s>0 → BUSY, loading the s-bit down-counter.
  - MUL → BUSY, loading an N-step counter.
- BUSY: one bit of shift (or one shift-add step) per cycle. When the counter reaches 0, the final result and flags are registered → DONE.
- DONE with OutReady=1:
  - no accept → IDLE;
  - accept → the new op's path, as from IDLE.
- DONE with OutReady=0: hold Y and all flags stable.
- Operands and F are captured at accept. Input changes while BUSY are ignored.

## Timing

- Reset (nReset=0 at an edge):
  - state IDLE, counter 0;
  - Y=0, Negative=0, Zero=0, Carry=0, Overflow=0, OutValid=0;
  - InReady=1 in the cycle after reset deasserts.
- Reset takes effect in any state. A mid-BUSY op is discarded with no output.
- Latency from the accept edge k:
  - single-cycle ops: OutValid after edge k;
  - shift by s: OutValid after edge k+s;
  - MUL: OutValid after edge k+N.
- Back-to-back single-cycle ops with OutReady held at 1: one result per cycle, no bubble.
- InReady is combinational from state and OutReady only. It never depends on InValid.
- Shift by N-1 is the maximum. Amount bits above SH-1 are ignored, so B=N behaves as shift by 0.

## Configuration

- ALU_SEQ_MUL_EN defined:
  - F=1101 is an unsigned shift-add multiply, N iterations.
  - Y = low N bits of A*B.
  - Carry = 1 if the high N bits are nonzero; Overflow=0.
- ALU_SEQ_MUL_EN undefined:
  - no multiplier logic is built;
  - F=1101 is a reserved op (Y=0, Zero=1, single-cycle).

## Test plan

All cases use N=32.
- ADD A=0x7FFFFFFF, B=1 → Y=0x80000000, Negative=1, Zero=0, Carry=0, Overflow=1; OutValid after the accept edge.
- SUB A=5, B=5 → Y=0, Zero=1, Carry=1, Overflow=0. SUB A=0, B=1 → Y=0xFFFFFFFF, Carry=0.
- SLT A=0x80000000, B=1 → Y=1. SLTU with the same operands → Y=0. SLT A=0x7FFFFFFF, B=0xFFFFFFFF → Y=0.
- SRA A=0x80000010, B=4:
  - Y=0xF8000001, Carry=0;
  - InReady=0 for 4 cycles; OutValid after edge k+4.
- Reset and backpressure:
  - OutReady=0 for 3 cycles after DONE → Y and flags stable;
  - SLL by 20 with nReset pulled low 5 cycles after accept → next cycle OutValid=0, InReady=1, Y=0.
- With ALU_SEQ_MUL_EN: MUL 0xFFFF × 0x10001 → Y=0xFFFFFFFF, Carry=0, OutValid after edge k+32.
- Without ALU_SEQ_MUL_EN: the same stimulus → Y=0, Zero=1, OutValid after edge k.
